// File: rtl/al_accel_wload_ctrl.sv
// al_accel_wload_ctrl: 3x3 kernel weight-load sequencer; define AL_ACCEL_WLOAD_STALL_CNT_EN for load_stall_cnt
module al_accel_wload_ctrl #(
   parameter int DW     = 8,
   parameter int KIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [KIDX_W-1:0] cfg_num_krn,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [3*DW-1:0]   w_data,
   output logic [1:0]        wdemux_sel,
   output logic [DW-1:0]     wdemux_di_0,
   output logic [DW-1:0]     wdemux_di_1,
   output logic [DW-1:0]     wdemux_di_2,
   output logic [2:0]        wreg_we,
   output logic              krn_valid,
   output logic [KIDX_W-1:0] krn_idx,
   input  logic              krn_release,
   output logic              busy,
`ifdef AL_ACCEL_WLOAD_STALL_CNT_EN
   output logic [15:0]       load_stall_cnt,
`endif
   output logic              layer_done
);
   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, HOLD} state_t;
   state_t state;
   logic [1:0] row;
   logic [KIDX_W-1:0] cfg_q;
   logic accept;
   assign w_ready = state == LOAD;
   assign accept  = w_ready & w_valid;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row         <= '0;
         cfg_q       <= '0;
         wdemux_sel  <= '0;
         wdemux_di_0 <= '0;
         wdemux_di_1 <= '0;
         wdemux_di_2 <= '0;
         wreg_we     <= '0;
         krn_valid   <= 1'b0;
         krn_idx     <= '0;
         busy        <= 1'b0;
         layer_done  <= 1'b0;
      end else begin
         wreg_we    <= '0;
         layer_done <= 1'b0;
         // a handshaken beat always reaches the registers, even alongside abort
         if (accept) begin
            wdemux_sel  <= row;
            wdemux_di_0 <= w_data[DW-1:0];
            wdemux_di_1 <= w_data[2*DW-1:DW];
            wdemux_di_2 <= w_data[3*DW-1:2*DW];
            wreg_we     <= 3'b001 << row;
         end
         if (abort) begin
            state     <= IDLE;
            row       <= '0;
            krn_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state   <= LOAD;
                  row     <= '0;
                  krn_idx <= '0;
                  cfg_q   <= cfg_num_krn;
                  busy    <= 1'b1;
               end
               LOAD: if (w_valid) begin
                  state <= row == 2'd2 ? SETTLE : LOAD;
                  row   <= row == 2'd2 ? 2'd0 : row + 2'd1;
               end
               SETTLE: state <= HOLD;
               HOLD: begin
                  krn_valid <= !krn_release;
                  if (krn_release) begin
                     if (krn_idx == cfg_q) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        layer_done <= 1'b1;
                     end else begin
                        state   <= LOAD;
                        row     <= '0;
                        krn_idx <= krn_idx + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
`ifdef AL_ACCEL_WLOAD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start && !abort)) load_stall_cnt <= '0;
      else if (state == LOAD && !w_valid && load_stall_cnt != 16'hFFFF) load_stall_cnt <= load_stall_cnt + 16'd1;
   end
`endif
endmodule
